// File: rtl/core_ecc_chk.sv
// Hamming(7,4)-style checker for an 11-bit codeword with a 2-entry output FIFO.
// Optional statistics counters are compiled in with CORE_ECC_STATS_EN.
module core_ecc_chk #(
  parameter int CNT_W   = 16,
  parameter int CORRECT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [10:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_err,
  output logic [2:0]       out_syn,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       err;
    logic [2:0] syn;
  } entry_t;

  state_t state_q, state_d;
  entry_t head_q, head_d;
  entry_t tail_q, tail_d;
  entry_t new_entry;

  logic [2:0]  syn;
  logic [10:0] flip_mask;
  logic [10:0] fixed;
  logic        push;
  logic        pop;

  // Syndrome value k points at codeword bit k+3; header bits [3:0] are outside the code.
  assign syn = {in_data[7] ^ in_data[8] ^ in_data[9] ^ in_data[10],
                in_data[5] ^ in_data[6] ^ in_data[9] ^ in_data[10],
                in_data[4] ^ in_data[6] ^ in_data[8] ^ in_data[10]};

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    flip_mask = '0;
    for (int i = 4; i <= 10; i++) begin
      if (CORRECT != 0 && syn == 3'(i - 3)) flip_mask[i] = 1'b1;
    end
  end

  assign fixed          = in_data ^ flip_mask;
  assign new_entry.data = {fixed[10], fixed[9], fixed[8], fixed[6], fixed[3:0]};
  assign new_entry.err  = |syn;
  assign new_entry.syn  = syn;

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          head_d  = new_entry;
        end
      end
      ONE: begin
        unique case ({push, pop})
          2'b10: begin
            state_d = TWO;
            tail_d  = new_entry;
          end
          2'b01:   state_d = EMPTY;
          2'b11:   head_d  = new_entry;
          default: ;
        endcase
      end
      TWO: begin
        if (pop) begin
          state_d = ONE;
          head_d  = tail_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // NOTE: both slots are reset (not just the state) so out_data/out_err/out_syn read 0 during reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign out_data = head_q.data;
  assign out_err  = head_q.err;
  assign out_syn  = head_q.syn;

`ifdef CORE_ECC_STATS_EN
  logic [CNT_W-1:0] word_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else if (push) begin
      if (word_cnt_q != '1) word_cnt_q <= word_cnt_q + 1'b1;
      if (new_entry.err && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign word_cnt = word_cnt_q;
  assign err_cnt  = err_cnt_q;
`else
  assign word_cnt = '0;
  assign err_cnt  = '0;
`endif

endmodule
